pkt_queue_drain_sched: RTL and testbench



---
 rtl/pkt_queue_drain_sched.sv | 152 +++++++++++++++
 tb/tb_pkt_queue_drain_sched.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_queue_drain_sched.sv
// Drains one whole AXI-Stream packet per one-hot queue tag from four data-cache queues, in tag order.
// Optional SCHED_RR_ORDER_CHECK_EN: counts tags that break the round-robin queue sequence in err_cnt.
module pkt_queue_drain_sched #(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES         = 4,
    parameter int TAG_FIFO_DEPTH_BITS  = 3
) (
    input  logic                              axis_clk,
    input  logic                              reset,
    input  logic [C_NUM_QUEUES-1:0]           tag_in,
    input  logic                              tag_valid,
    output logic                              tag_ready,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_0,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_0,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_0,
    input  logic                              s_axis_tlast_0,
    input  logic                              s_axis_tvalid_0,
    output logic                              s_axis_tready_0,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_1,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_1,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_1,
    input  logic                              s_axis_tlast_1,
    input  logic                              s_axis_tvalid_1,
    output logic                              s_axis_tready_1,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_2,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_2,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_2,
    input  logic                              s_axis_tlast_2,
    input  logic                              s_axis_tvalid_2,
    output logic                              s_axis_tready_2,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata_3,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser_3,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep_3,
    input  logic                              s_axis_tlast_3,
    input  logic                              s_axis_tvalid_3,
    output logic                              s_axis_tready_3,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic                              busy,
    output logic [7:0]                        err_cnt
);

    localparam int DEPTH = 1 << TAG_FIFO_DEPTH_BITS;
    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [C_NUM_QUEUES-1:0][C_S_AXIS_DATA_WIDTH-1:0]   q_tdata;
    logic [C_NUM_QUEUES-1:0][C_S_AXIS_TUSER_WIDTH-1:0]  q_tuser;
    logic [C_NUM_QUEUES-1:0][C_S_AXIS_DATA_WIDTH/8-1:0] q_tkeep;
    logic [C_NUM_QUEUES-1:0]                            q_tlast;
    logic [C_NUM_QUEUES-1:0]                            q_tvalid;
    logic [C_NUM_QUEUES-1:0]                            q_tready;

    assign q_tdata  = {s_axis_tdata_3, s_axis_tdata_2, s_axis_tdata_1, s_axis_tdata_0};
    assign q_tuser  = {s_axis_tuser_3, s_axis_tuser_2, s_axis_tuser_1, s_axis_tuser_0};
    assign q_tkeep  = {s_axis_tkeep_3, s_axis_tkeep_2, s_axis_tkeep_1, s_axis_tkeep_0};
    assign q_tlast  = {s_axis_tlast_3, s_axis_tlast_2, s_axis_tlast_1, s_axis_tlast_0};
    assign q_tvalid = {s_axis_tvalid_3, s_axis_tvalid_2, s_axis_tvalid_1, s_axis_tvalid_0};
    assign {s_axis_tready_3, s_axis_tready_2, s_axis_tready_1, s_axis_tready_0} = q_tready;

    logic [0:0]                       state;
    logic [1:0]                       sel;
    logic [C_NUM_QUEUES-1:0]          tag_mem [DEPTH];
    logic [TAG_FIFO_DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
    logic [TAG_FIFO_DEPTH_BITS:0]     tag_cnt;
    logic                             tag_empty, tag_wr, tag_rd;
    logic [C_NUM_QUEUES-1:0]          head;
    logic                             head_onehot;
    logic [1:0]                       head_idx;
    logic                             order_err, err_inc, xfer_last;

    // Occupancy MSB set means all DEPTH entries are in use.
    assign tag_ready   = !tag_cnt[TAG_FIFO_DEPTH_BITS];
    assign tag_empty   = (tag_cnt == '0);
    assign tag_wr      = tag_valid && tag_ready;
    assign tag_rd      = (state == S_IDLE) && !tag_empty;
    assign head        = tag_mem[rd_ptr];
    assign head_onehot = $onehot(head);
    assign busy        = (state == S_STREAM);
    assign xfer_last   = busy && q_tvalid[sel] && m_axis_tready && q_tlast[sel];

    always_comb begin
        head_idx = 2'd0;
        for (int i = 0; i < C_NUM_QUEUES; i++)
            if (head[i]) head_idx = i[1:0];
    end

`ifdef SCHED_RR_ORDER_CHECK_EN
    logic [1:0] exp_q;
    assign order_err = head_onehot && (head_idx != exp_q);
    always_ff @(posedge axis_clk) begin
        if (reset)                      exp_q <= 2'd0;
        else if (tag_rd && head_onehot) exp_q <= head_idx + 2'd1;
    end
`else
    assign order_err = 1'b0;
`endif

    assign err_inc = tag_rd && (!head_onehot || order_err);

    always_ff @(posedge axis_clk)
        if (tag_wr) tag_mem[wr_ptr] <= tag_in;

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            state   <= S_IDLE;
            sel     <= 2'd0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
            err_cnt <= 8'd0;
        end else begin
            if (tag_wr) wr_ptr <= wr_ptr + 1'b1;
            if (tag_rd) rd_ptr <= rd_ptr + 1'b1;
            if (tag_wr && !tag_rd)      tag_cnt <= tag_cnt + 1'b1;
            else if (!tag_wr && tag_rd) tag_cnt <= tag_cnt - 1'b1;
            if (err_inc && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            if (state == S_IDLE) begin
                // Bad tags are dropped in place; only a one-hot tag starts a drain.
                if (tag_rd && head_onehot) begin
                    sel   <= head_idx;
                    state <= S_STREAM;
                end
            end else if (xfer_last) begin
                state <= S_IDLE;
            end
        end
    end

    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        m_axis_tkeep  = '0;
        m_axis_tlast  = 1'b0;
        m_axis_tvalid = 1'b0;
        q_tready      = '0;
        if (busy) begin
            m_axis_tdata   = q_tdata[sel];
            m_axis_tuser   = q_tuser[sel];
            m_axis_tkeep   = q_tkeep[sel];
            m_axis_tlast   = q_tlast[sel];
            m_axis_tvalid  = q_tvalid[sel];
            q_tready[sel]  = m_axis_tready;
        end
    end

endmodule

// File: tb/tb_pkt_queue_drain_sched.sv
// Bench for pkt_queue_drain_sched: directed scenarios plus random tags/packets checked against a tag-order packet model.
module tb_pkt_queue_drain_sched;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [UW-1:0] u;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    tag_in = 4'd0;
    logic          tag_valid = 1'b0;
    logic          tag_ready;
    logic [DW-1:0] s_tdata [4];
    logic [UW-1:0] s_tuser [4];
    logic [KW-1:0] s_tkeep [4];
    logic [3:0]    s_tlast = 4'd0;
    logic [3:0]    s_tvalid = 4'd0;
    logic          str0, str1, str2, str3;
    logic [3:0]    s_tready;
    logic [DW-1:0] m_tdata;
    logic [UW-1:0] m_tuser;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast, m_tvalid;
    logic          m_tready = 1'b1;
    logic          busy;
    logic [7:0]    err_cnt;

    assign s_tready = {str3, str2, str1, str0};

    always #5 clk = ~clk;

    pkt_queue_drain_sched dut (
        .axis_clk(clk), .reset(reset),
        .tag_in(tag_in), .tag_valid(tag_valid), .tag_ready(tag_ready),
        .s_axis_tdata_0(s_tdata[0]), .s_axis_tuser_0(s_tuser[0]), .s_axis_tkeep_0(s_tkeep[0]),
        .s_axis_tlast_0(s_tlast[0]), .s_axis_tvalid_0(s_tvalid[0]), .s_axis_tready_0(str0),
        .s_axis_tdata_1(s_tdata[1]), .s_axis_tuser_1(s_tuser[1]), .s_axis_tkeep_1(s_tkeep[1]),
        .s_axis_tlast_1(s_tlast[1]), .s_axis_tvalid_1(s_tvalid[1]), .s_axis_tready_1(str1),
        .s_axis_tdata_2(s_tdata[2]), .s_axis_tuser_2(s_tuser[2]), .s_axis_tkeep_2(s_tkeep[2]),
        .s_axis_tlast_2(s_tlast[2]), .s_axis_tvalid_2(s_tvalid[2]), .s_axis_tready_2(str2),
        .s_axis_tdata_3(s_tdata[3]), .s_axis_tuser_3(s_tuser[3]), .s_axis_tkeep_3(s_tkeep[3]),
        .s_axis_tlast_3(s_tlast[3]), .s_axis_tvalid_3(s_tvalid[3]), .s_axis_tready_3(str3),
        .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tkeep(m_tkeep),
        .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .busy(busy), .err_cnt(err_cnt)
    );

    // Model: source queues, the queue id expected for each pending packet, and the error count.
    beat_t src [4][$];
    int    exp_qid [$];
    int    err_model = 0, expq = 0;
    int    tests = 0, fails = 0;
    int    cyc_n = 0, xfer_cnt = 0, first_x = 0, last_x = 0, acc_cyc = 0;
    bit    last_acc = 1'b0, rand_ready = 1'b0;
    logic  snap_busy, snap_tready, snap_mvalid;
    logic [3:0] snap_str;
    logic [7:0] snap_err;

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic err_bump();
        if (err_model < 255) err_model++;
    endtask

    task automatic model_tag(input logic [3:0] t);
        int idx;
        if ($countones(t) == 1) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (t[i]) idx = i;
            exp_qid.push_back(idx);
`ifdef SCHED_RR_ORDER_CHECK_EN
            if (idx != expq) err_bump();
            expq = (idx + 1) % 4;
`endif
        end else begin
            err_bump();
        end
    endtask

    task automatic push_pkt(input int q, input int len);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.d = {8{$urandom}};
            b.u = {4{$urandom}};
            b.k = $urandom;
            b.l = (i == len - 1);
            src[q].push_back(b);
        end
    endtask

    task automatic flush_model();
        for (int q = 0; q < 4; q++) src[q].delete();
        exp_qid.delete();
        err_model = 0;
        expq = 0;
    endtask

    // One clock: drive at negedge, check handshakes just after, return 1 time unit past posedge.
    task automatic cyc();
        logic [3:0] popped;
        logic       xfer;
        int         q;
        @(negedge clk);
        if (rand_ready) m_tready = ($urandom_range(3) != 0);
        for (int i = 0; i < 4; i++) begin
            if (src[i].size() > 0) begin
                s_tvalid[i] = 1'b1;
                s_tdata[i]  = src[i][0].d;
                s_tuser[i]  = src[i][0].u;
                s_tkeep[i]  = src[i][0].k;
                s_tlast[i]  = src[i][0].l;
            end else begin
                s_tvalid[i] = 1'b0;
                s_tdata[i]  = '0;
                s_tuser[i]  = '0;
                s_tkeep[i]  = '0;
                s_tlast[i]  = 1'b0;
            end
        end
        #1;
        snap_busy = busy; snap_tready = tag_ready; snap_mvalid = m_tvalid;
        snap_str = s_tready; snap_err = err_cnt;
        popped = s_tready & s_tvalid;
        xfer = m_tvalid && m_tready;
        chk("single_tready", $countones(s_tready) <= 1, 1'b1);
        chk("pop_matches_xfer", popped != 4'd0, xfer);
        if (xfer && popped != 4'd0) begin
            q = 0;
            for (int i = 0; i < 4; i++) if (popped[i]) q = i;
            chk("pkt_pending", exp_qid.size() > 0, 1'b1);
            if (exp_qid.size() > 0) chk("queue_order", q, exp_qid[0]);
            chk("beat", {m_tdata, m_tuser, m_tkeep, m_tlast},
                {src[q][0].d, src[q][0].u, src[q][0].k, src[q][0].l});
            if (src[q][0].l && exp_qid.size() > 0) void'(exp_qid.pop_front());
            void'(src[q].pop_front());
            if (xfer_cnt == 0) first_x = cyc_n;
            last_x = cyc_n;
            xfer_cnt++;
        end
        last_acc = tag_valid && tag_ready;
        if (last_acc) begin
            acc_cyc = cyc_n;
            model_tag(tag_in);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic put_tag(input logic [3:0] t);
        int n;
        tag_in = t;
        tag_valid = 1'b1;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 500);
        tag_valid = 1'b0;
        chk("tag_accept", last_acc, 1'b1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_qid.size() > 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("drain_done", exp_qid.size(), 0);
        repeat (12) cyc();
    endtask

    initial begin
        int a0, n, t, q;
        logic [3:0] tpat;
        logic       pat [3];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;

        // Reset state, first cycle after release
        repeat (2) cyc();
        reset = 1'b0;
        cyc();
        chk("rst_busy", snap_busy, 1'b0);
        chk("rst_mvalid", snap_mvalid, 1'b0);
        chk("rst_err", snap_err, 8'd0);
        chk("rst_tag_ready", snap_tready, 1'b1);
        chk("rst_s_tready", snap_str, 4'd0);

        // Four 3-beat packets in tag order with one-cycle bubbles
        for (int i = 0; i < 4; i++) push_pkt(i, 3);
        xfer_cnt = 0;
        put_tag(4'b0001);
        a0 = acc_cyc;
        put_tag(4'b0010);
        put_tag(4'b0100);
        put_tag(4'b1000);
        drain();
        chk("t1_beats", xfer_cnt, 12);
        chk("t1_first_latency", first_x - a0, 2);
        chk("t1_span", last_x - first_x, 14);
        chk("t1_err", err_cnt, 8'd0);

        // Backpressure on a q2 packet; q3 holds an untagged decoy
        push_pkt(2, 2);
        push_pkt(3, 2);
        xfer_cnt = 0;
        put_tag(4'b0100);
        cyc();
        for (int i = 0; i < 3; i++) begin
            m_tready = pat[i];
            cyc();
            tpat = 4'b0100 & {4{pat[i]}};
            chk("t2_s_tready", snap_str, tpat);
        end
        m_tready = 1'b1;
        chk("t2_beats", xfer_cnt, 2);
        chk("t2_done", exp_qid.size(), 0);
        chk("t2_q3_untouched", src[3].size(), 2);
        src[3].delete();

        // Fill the tag FIFO while the FSM waits on a missing q0 packet
        put_tag(4'b0001);
        repeat (3) cyc();
        chk("t3_busy_wait", snap_busy, 1'b1);
        for (int i = 0; i < 8; i++) put_tag(4'b0010);
        tag_in = 4'b0010;
        tag_valid = 1'b1;
        cyc();
        chk("t3_full_ready", snap_tready, 1'b0);
        chk("t3_full_refuse", last_acc, 1'b0);
        push_pkt(0, 1);
        for (int i = 0; i < 9; i++) push_pkt(1, 1);
        n = 0;
        do begin
            cyc();
            n++;
        end while (!last_acc && n < 20);
        tag_valid = 1'b0;
        chk("t3_ready_return", n, 3);
        drain();
        chk("t3_err", err_cnt, err_model[7:0]);

        // Non-one-hot tags are dropped and counted
        a0 = err_model;
        push_pkt(0, 1);
        put_tag(4'b0000);
        put_tag(4'b0011);
        put_tag(4'b0001);
        drain();
        chk("t4_err", err_cnt, err_model[7:0]);
        chk("t4_bad_delta", err_model - a0 >= 2, 1'b1);

        // Reset during beat 2 of a 4-beat q1 packet
        push_pkt(1, 4);
        xfer_cnt = 0;
        put_tag(4'b0010);
        n = 0;
        while (xfer_cnt < 1 && n < 20) begin
            cyc();
            n++;
        end
        chk("t5_first_beat", xfer_cnt, 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        flush_model();
        cyc();
        chk("t5_busy", snap_busy, 1'b0);
        chk("t5_mvalid", snap_mvalid, 1'b0);
        chk("t5_err", snap_err, 8'd0);
        chk("t5_tag_ready", snap_tready, 1'b1);
        cyc();
        chk("t5_fifo_empty", snap_busy, 1'b0);

        // Out-of-order tags: counted only with the order check built in
        push_pkt(0, 1);
        push_pkt(2, 1);
        xfer_cnt = 0;
        put_tag(4'b0001);
        put_tag(4'b0100);
        drain();
        chk("t6_beats", xfer_cnt, 2);
`ifdef SCHED_RR_ORDER_CHECK_EN
        chk("t6_err_rr", err_cnt, 8'd1);
`else
        chk("t6_err", err_cnt, 8'd0);
`endif

        // Random tags, packet lengths and downstream backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(99) < 85) begin
                q = $urandom_range(3);
                push_pkt(q, $urandom_range(4, 1));
                tpat = 4'b0001 << q;
            end else begin
                do begin
                    t = $urandom_range(15);
                end while ($countones(t[3:0]) == 1);
                tpat = t[3:0];
            end
            put_tag(tpat);
            repeat ($urandom_range(2)) cyc();
        end
        drain();
        rand_ready = 1'b0;
        m_tready = 1'b1;
        chk("rand_err", err_cnt, err_model[7:0]);
        chk("rand_src_empty", src[0].size() + src[1].size() + src[2].size() + src[3].size(), 0);

        // err_cnt saturation
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        flush_model();
        for (int i = 0; i < 260; i++) put_tag(4'b0000);
        drain();
        chk("sat_err", err_cnt, 8'd255);
        chk("sat_model", err_cnt, err_model[7:0]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
